// File: rtl/reg_file_pkg.sv
// Shared sizing constants for the register file and its read ports.
// NUM_REGS is derived from the address width so the two can never disagree.
package reg_file_pkg;

    localparam int DEFAULT_ADDR_WIDTH = 3;
    localparam int DEFAULT_REG_WIDTH  = 32;
    localparam int DEFAULT_NUM_REGS   = 2 ** DEFAULT_ADDR_WIDTH;

    // A write is forwarded to a read port only while it is actually being requested.
    function automatic logic bypass_hit(input logic write_en,
                                        input logic [31:0] rd_addr,
                                        input logic [31:0] wr_addr);
        return write_en && (rd_addr == wr_addr);
    endfunction

endpackage

// File: rtl/reg_file_rd_port.sv
// One combinational read port: selects a stored register and, when the pending
// write targets the same address, forwards the write data instead.
module reg_file_rd_port
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEFAULT_REG_WIDTH,
    parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
    input  logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs,
    input  logic [ADDR_WIDTH-1:0]              rd_addr,
    input  logic [ADDR_WIDTH-1:0]              wr_addr,
    input  logic [REG_WIDTH-1:0]               wr_val,
    input  logic                               write_en,
    output logic [REG_WIDTH-1:0]               rd_val
);

    logic [31:0] rd_addr_ext;
    logic [31:0] wr_addr_ext;
    logic        hit;

    assign rd_addr_ext = 32'(rd_addr);
    assign wr_addr_ext = 32'(wr_addr);
    assign hit         = bypass_hit(write_en, rd_addr_ext, wr_addr_ext);

    // Bypass keeps the output stable across the write edge: the same value is
    // shown before the edge (forwarded) and after it (from storage).
    always_comb begin
        rd_val = regs[rd_addr];
        if (hit) begin
            rd_val = wr_val;
        end
    end

endmodule

// File: rtl/reg_file.sv
// Register file with one write port and two independent combinational read
// ports, each with write-through bypass. Reset clears every register.
module reg_file
    import reg_file_pkg::*;
#(
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int REG_WIDTH  = DEFAULT_REG_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [ADDR_WIDTH-1:0] i_reg_a_addr_r,
    input  logic [ADDR_WIDTH-1:0] i_reg_b_addr_r,
    input  logic [ADDR_WIDTH-1:0] i_reg_addr_w,
    input  logic [REG_WIDTH-1:0]  i_reg_val_w,
    input  logic                  i_write_en,
    output logic [REG_WIDTH-1:0]  o_reg_a_val_r,
    output logic [REG_WIDTH-1:0]  o_reg_b_val_r
);

    localparam int NUM_REGS = 2 ** ADDR_WIDTH;

    logic [NUM_REGS-1:0][REG_WIDTH-1:0] regs;

    // Register 0 is an ordinary register; reset takes priority over any write.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            regs <= '0;
        end else if (i_write_en) begin
            regs[i_reg_addr_w] <= i_reg_val_w;
        end
    end

    reg_file_rd_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_port_a (
        .regs    (regs),
        .rd_addr (i_reg_a_addr_r),
        .wr_addr (i_reg_addr_w),
        .wr_val  (i_reg_val_w),
        .write_en(i_write_en),
        .rd_val  (o_reg_a_val_r)
    );

    reg_file_rd_port #(
        .ADDR_WIDTH(ADDR_WIDTH),
        .REG_WIDTH (REG_WIDTH),
        .NUM_REGS  (NUM_REGS)
    ) u_rd_port_b (
        .regs    (regs),
        .rd_addr (i_reg_b_addr_r),
        .wr_addr (i_reg_addr_w),
        .wr_val  (i_reg_val_w),
        .write_en(i_write_en),
        .rd_val  (o_reg_b_val_r)
    );

endmodule

// File: tb/tb_reg_file.sv
// Self-checking bench for reg_file: directed scenarios followed by random traffic,
// all compared against an array-based model of the register contents.
module tb_reg_file;

    localparam int AW = 3;
    localparam int RW = 32;
    localparam int NR = 2 ** AW;

    logic          clk = 1'b0;
    logic          rst;
    logic [AW-1:0] a_addr, b_addr, w_addr;
    logic [RW-1:0] w_val;
    logic          we;
    logic [RW-1:0] a_val, b_val;

    int checks = 0;
    int passes = 0;

    logic [RW-1:0] model [NR];

    always #5 clk = ~clk;

    reg_file #(.ADDR_WIDTH(AW), .REG_WIDTH(RW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_reg_a_addr_r(a_addr),
        .i_reg_b_addr_r(b_addr),
        .i_reg_addr_w  (w_addr),
        .i_reg_val_w   (w_val),
        .i_write_en    (we),
        .o_reg_a_val_r (a_val),
        .o_reg_b_val_r (b_val)
    );

    task automatic checkOutput(input string tag, input logic [RW-1:0] got, input logic [RW-1:0] exp);
        checks++;
        if (got === exp) passes++;
        else $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Expected read: a pending write to the same address is forwarded, otherwise the stored value.
    function automatic logic [RW-1:0] expectRead(input logic [AW-1:0] addr);
        if (we && addr == w_addr) return w_val;
        return model[addr];
    endfunction

    task automatic clearModel();
        for (int i = 0; i < NR; i++) model[i] = '0;
    endtask

    task automatic checkPorts(input string tag);
        checkOutput({tag, "_a"}, a_val, expectRead(a_addr));
        checkOutput({tag, "_b"}, b_val, expectRead(b_addr));
    endtask

    // One cycle: drive after the falling edge, check before and after the rising edge.
    task automatic applyStimulus(input logic r, input logic [AW-1:0] aa, input logic [AW-1:0] ba,
                                 input logic [AW-1:0] wa, input logic [RW-1:0] wv, input logic wen,
                                 input string tag);
        @(negedge clk);
        rst = r; a_addr = aa; b_addr = ba; w_addr = wa; w_val = wv; we = wen;
        if (r) clearModel();
        #1;
        checkPorts({tag, "_pre"});
        @(posedge clk);
        if (!r && wen) model[wa] = wv;
        #1;
        checkPorts({tag, "_post"});
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1; a_addr = '0; b_addr = '0; w_addr = '0; w_val = '0; we = 1'b0;
        clearModel();
        repeat (2) @(posedge clk);

        // Every register reads 0 after reset, on both ports.
        for (int i = 0; i < NR; i++) begin
            applyStimulus(1'b0, AW'(i), AW'(NR - 1 - i), '0, '0, 1'b0, "rst_read");
            checkOutput("rst_zero_a", a_val, '0);
        end

        // Register i gets value i, then read back in pairs.
        for (int i = 0; i < NR; i++)
            applyStimulus(1'b0, '0, '0, AW'(i), RW'(i), 1'b1, "fill");
        for (int i = 0; i < NR; i += 2) begin
            applyStimulus(1'b0, AW'(i), AW'(i + 1), '0, '0, 1'b0, "pair");
            checkOutput("pair_a", a_val, RW'(i));
            checkOutput("pair_b", b_val, RW'(i + 1));
        end

        // Port A bypass, then hold after the write enable drops.
        applyStimulus(1'b0, 3'd2, 3'd0, 3'd2, 32'd23, 1'b1, "byp_a");
        checkOutput("byp_a_hold", a_val, 32'd23);
        applyStimulus(1'b0, 3'd2, 3'd0, 3'd2, 32'd99, 1'b0, "byp_a_off");
        checkOutput("byp_a_off", a_val, 32'd23);

        // Port B bypass.
        applyStimulus(1'b0, 3'd1, 3'd4, 3'd4, 32'd67, 1'b1, "byp_b");
        checkOutput("byp_b_hold", b_val, 32'd67);

        // Both ports bypass together, then only one matches.
        applyStimulus(1'b0, 3'd5, 3'd5, 3'd5, 32'hDEADBEEF, 1'b1, "byp_ab");
        checkOutput("byp_ab_a", a_val, 32'hDEADBEEF);
        checkOutput("byp_ab_b", b_val, 32'hDEADBEEF);
        applyStimulus(1'b0, 3'd5, 3'd3, 3'd5, 32'hCAFEF00D, 1'b1, "byp_one");
        checkOutput("byp_one_b", b_val, 32'd3);

        // Mid-cycle reset: contents clear at once and a write under reset is dropped.
        @(negedge clk);
        a_addr = 3'd6; b_addr = 3'd7; w_addr = 3'd1; w_val = 32'h55; we = 1'b1;
        #2;
        rst = 1'b1;
        clearModel();
        #1;
        checkOutput("midrst_a", a_val, '0);
        checkOutput("midrst_b", b_val, '0);
        @(posedge clk);
        #1;
        checkPorts("midrst_edge");
        applyStimulus(1'b1, 3'd6, 3'd1, 3'd6, 32'h77, 1'b1, "rst_byp");
        checkOutput("rst_byp_a", a_val, 32'h77);
        checkOutput("rst_byp_b", b_val, '0);
        applyStimulus(1'b0, 3'd1, 3'd6, 3'd0, '0, 1'b0, "post_rst");
        checkOutput("post_rst_a", a_val, '0);
        checkOutput("post_rst_b", b_val, '0);

        // Random traffic with occasional reset.
        for (int n = 0; n < 400; n++) begin
            applyStimulus(($urandom_range(0, 24) == 0),
                          AW'($urandom_range(0, NR - 1)), AW'($urandom_range(0, NR - 1)),
                          AW'($urandom_range(0, NR - 1)), RW'($urandom()),
                          ($urandom_range(0, 1) == 1), "rand");
        end

        // Final sweep of stored contents with writes disabled.
        for (int i = 0; i < NR; i++)
            applyStimulus(1'b0, AW'(i), AW'(NR - 1 - i), '0, '0, 1'b0, "sweep");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/reg_file.md
REG_FILE -- requirements
Module: reg_file

Interface
REQ-001 Parameter ADDR_WIDTH, default 3, address width; the block SHALL hold NUM_REGS = 2**ADDR_WIDTH registers.
REQ-002 Parameter REG_WIDTH, default 32, width of each register and of every data port.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates occur on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 Port i_reg_a_addr_r, input, ADDR_WIDTH: read port A address.
REQ-006 Port i_reg_b_addr_r, input, ADDR_WIDTH: read port B address.
REQ-007 Port i_reg_addr_w, input, ADDR_WIDTH: write address.
REQ-008 Port i_reg_val_w, input, REG_WIDTH: write data.
REQ-009 Port i_write_en, input, 1 bit: write enable, active-high.
REQ-010 Port o_reg_a_val_r, output, REG_WIDTH: read port A data.
REQ-011 Port o_reg_b_val_r, output, REG_WIDTH: read port B data.

Function
REQ-012 Storage SHALL be NUM_REGS registers of REG_WIDTH bits, all independently writable, including register 0 (no hardwired-zero register).
REQ-013 Write: on a rising i_clk edge with i_write_en=1 and i_rst=0, register[i_reg_addr_w] SHALL take i_reg_val_w; no other register changes.
REQ-014 With i_write_en=0, no register SHALL change.
REQ-015 Reads SHALL be combinational, zero cycles of latency: o_reg_a_val_r reflects i_reg_a_addr_r and o_reg_b_val_r reflects i_reg_b_addr_r within the same delta, with no clock edge.
REQ-016 Write-through bypass: while i_write_en=1 and a read address equals i_reg_addr_w, that port SHALL output i_reg_val_w combinationally, before the write edge.
REQ-017 After the write edge, the same port SHALL keep returning the written value from storage, so the output does not glitch when i_write_en drops.
REQ-018 Ports A and B SHALL operate independently: they may carry equal or different addresses, and both may bypass simultaneously.
REQ-019 All addresses are full-range; there are no out-of-range cases, and wrap-around is implicit in ADDR_WIDTH.
REQ-020 Outputs SHALL never be X once reset has been applied and the inputs are known.

Reset
REQ-021 While i_rst=1, asynchronously and independent of i_clk, all registers SHALL clear to 0.
REQ-022 While i_rst=1, writes SHALL be ignored.
REQ-023 During reset, read outputs SHALL show the cleared contents (0), except that the bypass path still forwards i_reg_val_w when i_write_en=1 and the addresses match.
REQ-024 A reset asserted in the same cycle as a write SHALL win; the register holds 0 after reset is released.

Structure
REQ-025 A shared package reg_file_pkg SHALL hold the default ADDR_WIDTH and REG_WIDTH constants and the derived NUM_REGS.
REQ-026 One sub-module, reg_file_rd_port, SHALL implement a single read port: the address mux plus the write-bypass compare/select. It SHALL be instantiated twice, for port A and port B.
REQ-027 Storage and write logic SHALL reside in reg_file itself, with no latches.

Verification
REQ-028 Reset, then read all addresses on both ports -> every read returns 0.
REQ-029 Write value i to register i for i=0..7, one write per cycle; then read (A,B) pairs (0,1),(2,3),(4,5),(6,7) -> A=i, B=i+1.
REQ-030 Port A bypass: assert write of 23 to register 2 and set A addr=2 -> o_reg_a_val_r=23 before the clock edge; still 23 after the edge and after i_write_en drops.
REQ-031 Port B bypass: write 67 to register 4 with B addr=4 -> o_reg_b_val_r=67 before the edge; still 67 after it.
REQ-032 Both ports read register 5 while 0xDEADBEEF is written to register 5 -> both outputs show 0xDEADBEEF; a non-matching port keeps its stored value.
REQ-033 Assert i_rst mid-sequence between clock edges -> all registers read 0 immediately; a write pending on the next edge while reset is held is discarded.
